// File: rtl/neuron_pe_accumulator.sv
// Accumulates N_TERMS unsigned Q5.3 products plus a bias and emits one Q5.3 pre-activation.
// Define NEURON_PE_ACC_SAT_EN to saturate the result at 8'hFF instead of wrapping modulo 256.
module neuron_pe_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bias,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       clear,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_next;
    logic [ACC_W-1:0]   w_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [7:0]         r_out_data;
    logic [7:0]         w_out_data_next;
    logic [7:0]         w_narrow;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_last;

    assign in_ready   = (r_state != DONE);
    assign out_valid  = (r_state == DONE);
    assign busy       = (r_state != IDLE);
    assign out_data   = r_out_data;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    // The first term of a group starts from the bias rather than the stale accumulator.
    assign w_sum = ((r_state == IDLE) ? {{(ACC_W-8){1'b0}}, bias} : r_acc)
                 + {{(ACC_W-8){1'b0}}, in_data};

    assign w_last = (r_state == IDLE) ? (N_TERMS == 1)
                                      : (r_cnt == CNT_W'(N_TERMS - 1));

`ifdef NEURON_PE_ACC_SAT_EN
    assign w_narrow = (w_sum > ACC_W'(8'hFF)) ? 8'hFF : w_sum[7:0];
`else
    assign w_narrow = w_sum[7:0];
`endif

    always_comb begin
        w_state_next    = r_state;
        w_acc_next      = r_acc;
        w_cnt_next      = r_cnt;
        w_out_data_next = r_out_data;
        if (clear) begin
            w_state_next = IDLE;
            w_acc_next   = '0;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                IDLE, ACC: begin
                    if (w_in_xfer) begin
                        w_acc_next = w_sum;
                        w_cnt_next = (r_state == IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
                        if (w_last) begin
                            w_state_next    = DONE;
                            w_out_data_next = w_narrow;
                        end else begin
                            w_state_next = ACC;
                        end
                    end
                end
                DONE: begin
                    if (w_out_xfer) begin
                        w_state_next = IDLE;
                        w_acc_next   = '0;
                        w_cnt_next   = '0;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_acc_next   = '0;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_out_data <= 8'h00;
        end else begin
            r_state    <= w_state_next;
            r_acc      <= w_acc_next;
            r_cnt      <= w_cnt_next;
            r_out_data <= w_out_data_next;
        end
    end

endmodule

// File: tb/tb_neuron_pe_accumulator.sv
// Directed bench for neuron_pe_accumulator: a queue-based group model checked every cycle
// plus literal expectations for the headline scenarios.
module tb_neuron_pe_accumulator;

    localparam int N = 4;
`ifdef NEURON_PE_ACC_SAT_EN
    localparam logic [7:0] SAT_EXP = 8'hFF;
`else
    localparam logic [7:0] SAT_EXP = 8'h20;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bias;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       clear;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 0;

    always #5 clk = ~clk;

    neuron_pe_accumulator #(.N_TERMS(N), .ACC_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bias      (bias),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .clear     (clear),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: collect the accepted terms of a group, sum them with plain integers on completion.
    int         m_terms[$];
    int         m_bias;
    int         m_total;
    bit         m_have = 0;
    logic [7:0] m_out;

    always @(posedge clk) begin
        if (rst || clear) begin
            m_terms.delete();
            m_have = 0;
        end else if (m_have) begin
            if (out_ready) m_have = 0;
        end else if (in_valid) begin
            if (m_terms.size() == 0) m_bias = int'(bias);
            m_terms.push_back(int'(in_data));
            if (m_terms.size() == N) begin
                m_total = m_bias;
                foreach (m_terms[k]) m_total += m_terms[k];
`ifdef NEURON_PE_ACC_SAT_EN
                m_out = (m_total > 255) ? 8'hFF : 8'(m_total);
`else
                m_out = 8'(m_total % 256);
`endif
                m_have = 1;
                m_terms.delete();
                $display("model: group done total=%0d out=%h", m_total, m_out);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", {7'd0, in_ready}, {7'd0, !m_have});
            chk("out_valid", {7'd0, out_valid}, {7'd0, m_have});
            chk("busy", {7'd0, busy}, {7'd0, (m_have || m_terms.size() > 0)});
            if (m_have) chk("out_data", out_data, m_out);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = d;
        bias     = b;
        step();
        in_valid = 1'b0;
        bias     = 8'h5A;
        $display("send: data=%h bias=%h", d, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Output must be visible exactly one cycle after the final term transferred.
    task automatic expect_out(input logic [7:0] exp, input string nm);
        @(negedge clk);
        chk({nm, "_valid"}, {7'd0, out_valid}, 8'd1);
        chk({nm, "_data"}, out_data, exp);
        $display("result %s: out_data=%h", nm, out_data);
        step();
    endtask

    task automatic expect_reset_state(input string nm);
        @(negedge clk);
        chk({nm, "_out_data"}, out_data, 8'h00);
        chk({nm, "_out_valid"}, {7'd0, out_valid}, 8'd0);
        chk({nm, "_in_ready"}, {7'd0, in_ready}, 8'd1);
        chk({nm, "_busy"}, {7'd0, busy}, 8'd0);
    endtask

    initial begin
        rst = 1'b1; bias = 8'h00; in_data = 8'h00; in_valid = 1'b0;
        clear = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        started = 1;
        step();
        rst = 1'b0;
        expect_reset_state("reset");
        step();

        // Basic sum: 0.5 + 4*1.0 = 4.5
        send(8'h08, 8'h04);
        for (int i = 0; i < 3; i++) send(8'h08, 8'hEE);
        expect_out(8'h24, "basic");

        // Stalls between terms
        send(8'h08, 8'h04); idle(2);
        send(8'h08, 8'hEE); idle(3);
        send(8'h08, 8'hEE); idle(1);
        send(8'h08, 8'hEE);
        expect_out(8'h24, "stall");

        // Sum of 800 overflows 8 bits
        for (int i = 0; i < 4; i++) send(8'hC8, (i == 0) ? 8'h00 : 8'hEE);
        expect_out(SAT_EXP, "sat");

        // Backpressure: output held, offered input ignored
        out_ready = 1'b0;
        send(8'h02, 8'h01);
        for (int i = 0; i < 3; i++) send(8'h02, 8'hEE);
        in_valid = 1'b1; in_data = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {7'd0, out_valid}, 8'd1);
            chk("bp_in_ready", {7'd0, in_ready}, 8'd0);
            chk("bp_data", out_data, 8'h09);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {7'd0, out_valid}, 8'd1);
        step();
        @(negedge clk);
        chk("bp_after_valid", {7'd0, out_valid}, 8'd0);
        chk("bp_after_in_ready", {7'd0, in_ready}, 8'd1);
        step();

        // Abort after 2 beats; clear collides with a third beat
        send(8'h08, 8'h04);
        send(8'h08, 8'hEE);
        in_valid = 1'b1; in_data = 8'h08; clear = 1'b1;
        step();
        in_valid = 1'b0; clear = 1'b0;
        @(negedge clk);
        chk("abort_busy", {7'd0, busy}, 8'd0);
        step();
        for (int i = 0; i < 4; i++) send(8'h10, (i == 0) ? 8'h00 : 8'hEE);
        expect_out(8'h40, "abort_next");

        // clear while a result is waiting drops it
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h01, (i == 0) ? 8'h00 : 8'hEE);
        clear = 1'b1;
        step();
        clear = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("clear_done_valid", {7'd0, out_valid}, 8'd0);
        step();

        // Reset mid-group
        for (int i = 0; i < 3; i++) send(8'h08, (i == 0) ? 8'h04 : 8'hEE);
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_reset_state("midrst");
        step();
        send(8'h08, 8'h04);
        for (int i = 0; i < 3; i++) send(8'h08, 8'hEE);
        expect_out(8'h24, "after_rst");

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
